final_cpa_pipe: RTL and testbench
=================================

FINAL_CPA_PIPE -- requirements
Module: final_cpa_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 64, operand and result row width (even, >=8).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  R1/R2/R3 hold a valid row triple.
REQ-005 SHALL have port: in_ready  output  1  block accepts a triple this cycle.
REQ-006 SHALL have port: R1, R2, R3  input  WIDTH each  aligned partial-sum rows from the 5:3 compression tree.
REQ-007 SHALL have port: out_valid  output  1  P/COUT hold a valid result.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts the result this cycle.
REQ-009 SHALL have port: P  output  WIDTH  low WIDTH bits of R1+R2+R3.
REQ-010 SHALL have port: COUT  output  2  bits [WIDTH+1:WIDTH] of the exact sum R1+R2+R3.

Function
REQ-011 SHALL compute exact sum E = R1+R2+R3 (WIDTH+2 bits); {COUT,P} = E, no saturation.
REQ-012 SHALL be a 3-stage pipeline: S1 registers 3:2 CSA sum (R1^R2^R3) and carry (majority, shifted left 1, WIDTH+1 bits).
REQ-013 SHALL in S2 add the low WIDTH/2 bits of CSA sum and carry; register low result, carry-out, and unadded high halves.
REQ-014 SHALL in S3 add high halves plus registered S2 carry; register P and COUT.
REQ-015 SHALL keep a valid bit per stage (v1, v2, v3); out_valid = v3.
REQ-016 SHALL use global advance enable adv = !v3 || out_ready; all stage data and valid registers load only when adv = 1.
REQ-017 SHALL drive in_ready = adv (combinational from v3 and out_ready).
REQ-018 SHALL accept a triple on a cycle where in_valid && in_ready; on adv with !in_valid, v1 loads 0.
REQ-019 SHALL produce latency exactly 3 cycles from acceptance to out_valid when out_ready is held 1.
REQ-020 SHALL sustain throughput of one result per cycle with out_ready held 1.
REQ-021 SHALL hold P, COUT, out_valid stable while out_valid && !out_ready (no data loss, no reorder).
REQ-022 SHALL not collapse bubbles; interior empty stages still advance only with adv.
REQ-023 SHALL deliver results in acceptance order; no result is duplicated or dropped.
REQ-024 SHALL allow simultaneous accept and emit in one cycle (full pipeline, out_ready = 1, in_valid = 1).
REQ-025 SHALL ignore R1/R2/R3 contents when no accept occurs; register data content of invalid stages is don't-care.

Reset
REQ-026 SHALL on rst = 1 asynchronously clear v1, v2, v3 to 0, and P, COUT to 0.
REQ-027 SHALL drive in_ready = 1 and out_valid = 0 while rst is asserted and on first cycle after release.
REQ-028 SHALL discard all in-flight triples on reset mid-operation; no result for them appears after release.
REQ-029 SHALL accept a new triple on the first rising edge after rst deasserts if in_valid = 1.

Verification
REQ-030 SHALL pass: rst pulse mid-stream with 3 triples in flight -> out_valid = 0, P = 0, COUT = 0 immediately; no stale outputs afterwards.
REQ-031 SHALL pass: R1 = 3, R2 = 5, R3 = 7, out_ready = 1 -> 3 cycles later out_valid = 1, P = 15, COUT = 0.
REQ-032 SHALL pass: R1 = R2 = R3 = all-ones (64-bit) -> P = 0xFFFF_FFFF_FFFF_FFFD, COUT = 2.
REQ-033 SHALL pass: R1 = 0x0000_0000_FFFF_FFFF, R2 = 1, R3 = 0 -> P = 0x0000_0001_0000_0000, COUT = 0 (low-to-high carry across S2/S3).
REQ-034 SHALL pass: 10 back-to-back random triples, out_ready = 1 -> 10 consecutive out_valid cycles, results match E in order.
REQ-035 SHALL pass: out_ready held 0 for 5 cycles with pipeline full -> in_ready = 0, P/COUT frozen; on out_ready = 1, remaining results drain in order, none lost.

Source files
------------

// File: rtl/final_cpa_pipe.sv
// Final carry-propagate adder for three aligned partial-sum rows: 3:2 CSA, then a
// split two-stage add, with a global-stall valid/ready pipeline in front of the output.
module final_cpa_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] R1,
    input  logic [WIDTH-1:0] R2,
    input  logic [WIDTH-1:0] R3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] P,
    output logic [1:0]       COUT
);

    localparam int H = WIDTH / 2;

    logic             adv;
    logic             v1, v2, v3;

    // S1: carry-save form of the three rows
    logic [WIDTH-1:0] s1_sum;
    logic [WIDTH:0]   s1_carry;

    // S2: finished low half plus the still-unadded high halves
    logic [H-1:0]     s2_lo;
    logic             s2_c;
    logic [H-1:0]     s2_sum_hi;
    logic [H:0]       s2_carry_hi;

    logic [WIDTH-1:0] csa_sum;
    logic [WIDTH-1:0] csa_maj;
    logic [H:0]       lo_add;
    logic [H+1:0]     hi_add;

    // The whole pipe moves together: it stalls only when the output holds a result
    // that downstream is not taking.
    assign adv       = !v3 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    always_comb begin
        csa_sum = R1 ^ R2 ^ R3;
        csa_maj = (R1 & R2) | (R1 & R3) | (R2 & R3);
        lo_add  = {1'b0, s1_sum[H-1:0]} + {1'b0, s1_carry[H-1:0]};
        hi_add  = {2'b00, s2_sum_hi} + {1'b0, s2_carry_hi} + {{(H+1){1'b0}}, s2_c};
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples the
    // previous stage's value from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // NOTE: interior data registers carry no reset; their content only matters when
    // the matching valid bit is set, and the valid bits are reset.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sum      <= csa_sum;
            s1_carry    <= {csa_maj, 1'b0};
            s2_lo       <= lo_add[H-1:0];
            s2_c        <= lo_add[H];
            s2_sum_hi   <= s1_sum[WIDTH-1:H];
            s2_carry_hi <= s1_carry[WIDTH:H];
        end
    end

    // Output registers are visible at the ports, so they are cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            P    <= '0;
            COUT <= '0;
        end else if (adv) begin
            P    <= {hi_add[H-1:0], s2_lo};
            COUT <= hi_add[H+1:H];
        end
    end

endmodule

// File: tb/tb_final_cpa_pipe.sv
// Bench for final_cpa_pipe: table-driven vectors, random stream, stall and reset
// sequences, all checked through an in-order scoreboard of expected {COUT,P}.
module tb_final_cpa_pipe;

    localparam int W = 64;

    typedef struct {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic [W-1:0] r3;
        logic [W-1:0] p;
        logic [1:0]   cout;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] r1 = '0, r2 = '0, r3 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] p;
    logic [1:0]   cout;

    logic [W+1:0] cur_exp = '0;
    logic [W+1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           run = 0;
    int           max_run = 0;

    vec_t vecs[7];

    final_cpa_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .R1(r1), .R2(r2), .R3(r3),
        .out_valid(out_valid), .out_ready(out_ready),
        .P(p), .COUT(cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a, b, c);
        return {2'b00, a} + {2'b00, b} + {2'b00, c};
    endfunction

    // Scoreboard: push on accept, pop and compare on emit; sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("no_stale_out", {{(W+1){1'b0}}, out_valid}, '0);
                else
                    check("result", {cout, p}, exp_q.pop_front());
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) check("accept_timeout", '0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drive(input logic [W-1:0] a, b, c, input logic [W+1:0] e);
        r1 = a; r2 = b; r3 = c;
        cur_exp  = e;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [W-1:0] a, b, c, input logic [W+1:0] e);
        drive(a, b, c, e);
        wait_accept();
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", W'(exp_q.size()), '0);
        repeat (2) tick();
    endtask

    initial begin
        logic [W-1:0] a, b, c;
        int n, t0;

        vecs[0] = '{64'd3, 64'd5, 64'd7, 64'd15, 2'd0};
        vecs[1] = '{'1, '1, '1, 64'hFFFF_FFFF_FFFF_FFFD, 2'd2};
        vecs[2] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 64'd0, 64'h0000_0001_0000_0000, 2'd0};
        vecs[3] = '{64'd0, 64'd0, 64'd0, 64'd0, 2'd0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'd1};
        vecs[5] = '{'1, 64'd1, 64'd0, 64'd0, 2'd1};
        vecs[6] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 64'd0, 64'd0, 2'd1};

        // Reset state while rst is held
        repeat (2) tick();
        @(negedge clk);
        check("rst_in_ready", {{(W+1){1'b0}}, in_ready}, 1);
        check("rst_out_valid", {{(W+1){1'b0}}, out_valid}, 0);
        check("rst_out_data", {cout, p}, 0);
        tick();

        // Release and present a triple at once: accepted on the first edge, out 3 edges later
        rst = 1'b0;
        out_ready = 1'b1;
        drive(vecs[0].r1, vecs[0].r2, vecs[0].r3, {vecs[0].cout, vecs[0].p});
        #1;
        check("post_rst_out_valid", {{(W+1){1'b0}}, out_valid}, 0);
        check("post_rst_in_ready", {{(W+1){1'b0}}, in_ready}, 1);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check("latency", W'(n), 3);
        drain();

        // Table vectors back to back
        foreach (vecs[i]) send(vecs[i].r1, vecs[i].r2, vecs[i].r3, {vecs[i].cout, vecs[i].p});
        drain();

        // Ten random triples back to back: one accept and one result per cycle
        max_run = 0;
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            c = {$urandom(), $urandom()};
            send(a, b, c, model(a, b, c));
        end
        check("accept_cycles", W'(cyc - t0), 10);
        drain();
        check("emit_run", W'(max_run), 10);

        // Fill with out_ready low, then hold a fourth triple against a 5-cycle stall
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            c = {$urandom(), 32'(i)};
            send(a, b, c, model(a, b, c));
        end
        a = '1; b = {$urandom(), $urandom()}; c = 64'd12345;
        drive(a, b, c, model(a, b, c));
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", {{(W+1){1'b0}}, in_ready}, 0);
            check("stall_out_valid", {{(W+1){1'b0}}, out_valid}, 1);
            check("stall_frozen", {cout, p}, exp_q[0]);
            tick();
        end
        out_ready = 1'b1;
        wait_accept();
        drain();

        // Reset with three triples in flight: outputs clear at once, nothing emerges later
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = {$urandom(), $urandom()};
            send(a, a, a, model(a, a, a));
        end
        check("full_before_rst", {{(W+1){1'b0}}, out_valid}, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {{(W+1){1'b0}}, out_valid}, 0);
        check("mid_rst_out_data", {cout, p}, 0);
        check("mid_rst_in_ready", {{(W+1){1'b0}}, in_ready}, 1);
        exp_q.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("after_rst_out_valid", {{(W+1){1'b0}}, out_valid}, 0);
        repeat (6) tick();

        // Pipeline still works after the mid-stream reset
        send(vecs[1].r1, vecs[1].r2, vecs[1].r3, {vecs[1].cout, vecs[1].p});
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
